// File: rtl/data_writeback_stage_block.sv
// Writeback stage: M->W pipeline register, load-response wait with timeout,
// load extension and result select feeding the register-file write port.
module data_writeback_stage_block #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m_valid,
  input  logic            i_m_reg_write,
  input  logic [1:0]      i_m_result_src,
  input  logic [2:0]      i_m_funct3,
  input  logic [4:0]      i_m_rd_addr,
  input  logic [XLEN-1:0] i_m_alu_result,
  input  logic [XLEN-1:0] i_m_pc_plus4,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic [4:0]      o_result_addr,
  output logic [XLEN-1:0] o_final_result,
  output logic            o_en_regfile_write,
  output logic            o_w_fwd_valid,
  output logic            o_stall,
  output logic            o_load_err,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_MEM = 2'd2
  } state_t;

  localparam logic [4:0] TIMEOUT_CNT = 5'(LOAD_TIMEOUT);

  state_t            state;
  logic [4:0]        wait_cnt;
  logic              w_reg_write;
  logic [1:0]        w_result_src;
  logic [2:0]        w_funct3;
  logic [4:0]        w_rd;
  logic [XLEN-1:0]   w_alu;
  logic [XLEN-1:0]   w_pc4;

  logic              w_is_load;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wb_data;
  logic              complete;
  logic              done;
  logic              accept;

  assign w_is_load = (w_result_src == 2'b01);

  always_comb begin
    off     = w_alu[1:0];
    ld_byte = i_dmem_rdata[{off, 3'b000} +: 8];
    ld_half = i_dmem_rdata[{off[1], 4'b0000} +: 16];
    case (w_funct3)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = i_dmem_rdata;
    endcase
    // Reserved result_src 11 falls through to the ALU result.
    if (w_is_load)                  wb_data = load_data;
    else if (w_result_src == 2'b10) wb_data = w_pc4;
    else                            wb_data = w_alu;
  end

  // complete: the instruction retires this cycle with its (possible) write.
  always_comb begin
    complete   = 1'b0;
    o_stall    = 1'b0;
    o_load_err = 1'b0;
    case (state)
      ST_HOLD: begin
        if (!w_is_load || i_dmem_rvalid) complete = 1'b1;
        else                             o_stall  = 1'b1;
      end
      ST_WAIT_MEM: begin
        if (i_dmem_rvalid)                complete   = 1'b1;
        else if (wait_cnt == TIMEOUT_CNT) o_load_err = 1'b1;
        else                              o_stall    = 1'b1;
      end
      default: ;
    endcase
  end

  assign done               = complete | o_load_err;
  assign accept             = i_m_valid & ~o_stall;
  assign o_en_regfile_write = complete & w_reg_write;
  assign o_w_fwd_valid      = complete & w_reg_write;
  assign o_final_result     = complete ? wb_data : '0;
  assign o_result_addr      = w_rd;
  assign o_dbg_state        = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_EMPTY;
      wait_cnt     <= '0;
      w_reg_write  <= 1'b0;
      w_result_src <= '0;
      w_funct3     <= '0;
      w_rd         <= '0;
      w_alu        <= '0;
      w_pc4        <= '0;
    end else if (state == ST_EMPTY || done) begin
      wait_cnt <= '0;
      if (accept) begin
        state        <= ST_HOLD;
        w_reg_write  <= i_m_reg_write & (i_m_rd_addr != 5'd0);
        w_result_src <= i_m_result_src;
        w_funct3     <= i_m_funct3;
        w_rd         <= i_m_rd_addr;
        w_alu        <= i_m_alu_result;
        w_pc4        <= i_m_pc_plus4;
      end else begin
        state        <= ST_EMPTY;
        w_reg_write  <= 1'b0;
        w_result_src <= '0;
        w_funct3     <= '0;
        w_rd         <= '0;
        w_alu        <= '0;
        w_pc4        <= '0;
      end
    end else if (state == ST_HOLD) begin
      state    <= ST_WAIT_MEM;
      wait_cnt <= 5'd1;
    end else begin
      wait_cnt <= wait_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_data_writeback_stage_block.sv
// Directed bench for the writeback stage: ALU/PC+4 writes, x0 suppression,
// load extension, late load with M held, load timeout and reset mid-wait.
module tb_data_writeback_stage_block;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic        m_reg_write;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd_addr;
  logic [31:0] m_alu_result;
  logic [31:0] m_pc_plus4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  result_addr;
  logic [31:0] final_result;
  logic        en_regfile_write;
  logic        w_fwd_valid;
  logic        stall;
  logic        load_err;
  logic [1:0]  dbg_state;

  int n_total;
  int n_bad;

  data_writeback_stage_block #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_m_valid          (m_valid),
    .i_m_reg_write      (m_reg_write),
    .i_m_result_src     (m_result_src),
    .i_m_funct3         (m_funct3),
    .i_m_rd_addr        (m_rd_addr),
    .i_m_alu_result     (m_alu_result),
    .i_m_pc_plus4       (m_pc_plus4),
    .i_dmem_rvalid      (dmem_rvalid),
    .i_dmem_rdata       (dmem_rdata),
    .o_result_addr      (result_addr),
    .o_final_result     (final_result),
    .o_en_regfile_write (en_regfile_write),
    .o_w_fwd_valid      (w_fwd_valid),
    .o_stall            (stall),
    .o_load_err         (load_err),
    .o_dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_m(input logic rw, input logic [1:0] src, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
    m_valid      = 1'b1;
    m_reg_write  = rw;
    m_result_src = src;
    m_funct3     = f3;
    m_rd_addr    = rd;
    m_alu_result = alu;
    m_pc_plus4   = pc4;
  endtask

  task automatic idle_m();
    m_valid      = 1'b0;
    m_reg_write  = 1'b0;
    m_result_src = 2'b00;
    m_funct3     = 3'b000;
    m_rd_addr    = 5'd0;
    m_alu_result = 32'h0;
    m_pc_plus4   = 32'h0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_we"},    {31'b0, en_regfile_write}, 32'd1);
    check_eq({tag, "_fwd"},   {31'b0, w_fwd_valid},      32'd1);
    check_eq({tag, "_addr"},  {27'b0, result_addr},      {27'b0, rd});
    check_eq({tag, "_data"},  final_result,              data);
    check_eq({tag, "_stall"}, {31'b0, stall},            32'd0);
  endtask

  // Single-cycle load: accept, then rvalid in the first W cycle.
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] rdata, input logic [31:0] exp);
    next_cycle();
    drive_m(1'b1, 2'b01, f3, 5'd7, alu, 32'h0);
    next_cycle();
    idle_m();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    check_write(tag, 5'd7, exp);
    next_cycle();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    idle_m();
    repeat (2) @(posedge clk);
    next_cycle();
    check_eq("rst_we",    {31'b0, en_regfile_write}, 32'd0);
    check_eq("rst_addr",  {27'b0, result_addr},      32'd0);
    check_eq("rst_data",  final_result,              32'd0);
    check_eq("rst_stall", {31'b0, stall},            32'd0);
    check_eq("rst_state", {30'b0, dbg_state},        32'd0);
    rst = 1'b0;

    // ALU result, written exactly one cycle after acceptance
    next_cycle();
    drive_m(1'b1, 2'b00, 3'b010, 5'd5, 32'h1234_5678, 32'h0000_0100);
    #1;
    check_eq("alu_pre_we", {31'b0, en_regfile_write}, 32'd0);
    next_cycle();
    idle_m();
    #1;
    check_write("alu", 5'd5, 32'h1234_5678);
    next_cycle();
    check_eq("alu_once_we", {31'b0, en_regfile_write}, 32'd0);
    check_eq("alu_empty",   {30'b0, dbg_state},        32'd0);
    check_eq("alu_addr0",   {27'b0, result_addr},      32'd0);

    // x0 destination never written
    drive_m(1'b1, 2'b00, 3'b000, 5'd0, 32'hFFFF_FFFF, 32'h0);
    next_cycle();
    idle_m();
    #1;
    check_eq("x0_we",    {31'b0, en_regfile_write}, 32'd0);
    check_eq("x0_fwd",   {31'b0, w_fwd_valid},      32'd0);
    check_eq("x0_state", {30'b0, dbg_state},        32'd1);

    // PC+4 select, then reserved select acting as ALU, back to back
    next_cycle();
    drive_m(1'b1, 2'b10, 3'b000, 5'd1, 32'h0000_0AAA, 32'h0000_0104);
    next_cycle();
    drive_m(1'b1, 2'b11, 3'b000, 5'd2, 32'h0BAD_F00D, 32'h0000_0200);
    #1;
    check_write("pc4", 5'd1, 32'h0000_0104);
    next_cycle();
    idle_m();
    #1;
    check_write("rsv", 5'd2, 32'h0BAD_F00D);

    // load extension, data returned in the first W cycle
    quick_load("lb3",  3'b000, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
    quick_load("lbu3", 3'b100, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    quick_load("lhu2", 3'b101, 32'h0000_1002, 32'h80FF_0000, 32'h0000_80FF);
    quick_load("lh0",  3'b001, 32'h0000_1000, 32'h1234_8001, 32'hFFFF_8001);
    quick_load("lb1",  3'b000, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
    quick_load("lw",   3'b010, 32'h0000_1000, 32'hCAFE_BABE, 32'hCAFE_BABE);
    quick_load("f3x",  3'b111, 32'h0000_1001, 32'h8765_4321, 32'h8765_4321);

    // late load: M instruction held until the write cycle
    next_cycle();
    drive_m(1'b1, 2'b01, 3'b010, 5'd9, 32'h0000_2000, 32'h0);
    next_cycle();
    drive_m(1'b1, 2'b00, 3'b000, 5'd10, 32'h0000_000A, 32'h0);
    #1;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) next_cycle();
      check_eq($sformatf("late_stall%0d", i), {31'b0, stall},            32'd1);
      check_eq($sformatf("late_we%0d", i),    {31'b0, en_regfile_write}, 32'd0);
    end
    next_cycle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    check_write("late", 5'd9, 32'hDEAD_BEEF);
    next_cycle();
    dmem_rvalid = 1'b0;
    idle_m();
    #1;
    check_write("held", 5'd10, 32'h0000_000A);
    next_cycle();
    check_eq("held_empty", {30'b0, dbg_state}, 32'd0);

    // load timeout with LOAD_TIMEOUT = 4
    drive_m(1'b1, 2'b01, 3'b010, 5'd11, 32'h0000_3000, 32'h0);
    next_cycle();
    idle_m();
    #1;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) next_cycle();
      check_eq($sformatf("to_stall%0d", i), {31'b0, stall},    32'd1);
      check_eq($sformatf("to_err%0d", i),   {31'b0, load_err}, 32'd0);
    end
    next_cycle();
    check_eq("to_err",     {31'b0, load_err},         32'd1);
    check_eq("to_stall",   {31'b0, stall},            32'd0);
    check_eq("to_we",      {31'b0, en_regfile_write}, 32'd0);
    next_cycle();
    check_eq("to_err_off", {31'b0, load_err},         32'd0);
    check_eq("to_empty",   {30'b0, dbg_state},        32'd0);

    // reset while waiting for the load
    drive_m(1'b1, 2'b01, 3'b010, 5'd12, 32'h0000_4000, 32'h0);
    next_cycle();
    idle_m();
    next_cycle();
    check_eq("rw_waiting", {30'b0, dbg_state}, 32'd2);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rw_state", {30'b0, dbg_state},        32'd0);
    check_eq("rw_we",    {31'b0, en_regfile_write}, 32'd0);
    check_eq("rw_stall", {31'b0, stall},            32'd0);
    check_eq("rw_err",   {31'b0, load_err},         32'd0);
    check_eq("rw_addr",  {27'b0, result_addr},      32'd0);

    // stray rvalid while empty is ignored
    next_cycle();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    #1;
    check_eq("stray_we",   {31'b0, en_regfile_write}, 32'd0);
    check_eq("stray_data", final_result,              32'd0);
    dmem_rvalid = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
